eth_rx_narrow: RTL and testbench

ETH_RX_NARROW -- requirements
Module: eth_rx_narrow

---
 rtl/eth_rx_pkg.sv | 16 +
 rtl/eth_rx_buf.sv | 37 +++
 rtl/eth_rx_narrow.sv | 189 ++++++++++++++++++
 tb/tb_eth_rx_narrow.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the narrow Ethernet receive buffer.
package eth_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_DROP,
    S_READY,
    S_READY_DROP
  } state_e;

  localparam int MAX_BYTES_DEFAULT = 2048;
  localparam int LEN_W             = 12;
  localparam int DROP_W            = 16;

endpackage

// File: rtl/eth_rx_buf.sv
// Frame buffer: 2^ADDR_W x 64-bit words, one write port and one registered
// read port. Storage is not reset; only the read register is cleared.
module eth_rx_buf #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [63:0]       wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [63:0]       rdata_o
);

  logic [63:0] mem_q [0:(1<<ADDR_W)-1];
  logic [63:0] rdata_q;

  // Storage write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; holds its value when no read is requested.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/eth_rx_narrow.sv
// Byte-wide Ethernet receive path: packs bytes into 64-bit words, stores one
// good frame in a buffer for the host, and counts discarded frames.
module eth_rx_narrow
  import eth_rx_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_BYTES = MAX_BYTES_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  input  logic              rx_last_i,
  input  logic              rx_err_i,
  output logic              frame_ready_o,
  output logic [11:0]       frame_len_o,
  input  logic              frame_ack_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [63:0]       rd_data_o,
  output logic [15:0]       drop_cnt_o
);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [63:0]         pack_q, pack_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                ready_q, ready_d;
  logic [DROP_W-1:0]   drop_q, drop_d;

  logic                take;
  logic                drop_inc;
  logic [LEN_W-1:0]    idx;
  logic [63:0]         pack_base;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

  // Frame state machine and byte packing: decide where each byte goes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    len_d     = len_q;
    drop_inc  = 1'b0;
    take      = 1'b0;
    idx       = cnt_q;
    // A word written last cycle has left the pack register; start clean.
    pack_base = wr_q ? 64'd0 : pack_q;
    pack_d    = pack_base;

    case (state_q)
      S_IDLE: begin
        if (rx_valid_i) begin
          take      = 1'b1;
          idx       = '0;
          pack_base = 64'd0;
          if (rx_last_i) begin
            if (rx_err_i) begin
              drop_inc = 1'b1;
            end else begin
              state_d = S_READY;
              len_d   = LEN_W'(1);
            end
          end else begin
            state_d = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (rx_valid_i) begin
          if (cnt_q == LEN_W'(MAX_BYTES)) begin
            // One byte beyond the limit: the frame is too long.
            if (rx_last_i) begin
              state_d  = S_IDLE;
              drop_inc = 1'b1;
            end else begin
              state_d = S_DROP;
            end
          end else begin
            take = 1'b1;
            if (rx_last_i) begin
              if (rx_err_i) begin
                state_d  = S_IDLE;
                drop_inc = 1'b1;
              end else begin
                state_d = S_READY;
                len_d   = cnt_q + LEN_W'(1);
              end
            end
          end
        end
      end
      S_DROP: begin
        if (rx_valid_i && rx_last_i) begin
          state_d  = S_IDLE;
          drop_inc = 1'b1;
        end
      end
      S_READY: begin
        if (frame_ack_i) begin
          if (rx_valid_i && rx_last_i) begin
            state_d  = S_IDLE;
            drop_inc = 1'b1;
          end else if (rx_valid_i) begin
            state_d = S_DROP;
          end else begin
            state_d = S_IDLE;
          end
        end else if (rx_valid_i) begin
          if (rx_last_i) begin
            drop_inc = 1'b1;
          end else begin
            state_d = S_READY_DROP;
          end
        end
      end
      S_READY_DROP: begin
        if (rx_valid_i && rx_last_i) begin
          drop_inc = 1'b1;
          state_d  = frame_ack_i ? S_IDLE : S_READY;
        end else if (frame_ack_i) begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (take) begin
      pack_d                         = pack_base;
      pack_d[{idx[2:0], 3'b000} +: 8] = rx_data_i;
      cnt_d                          = idx + LEN_W'(1);
      wr_d                           = (idx[2:0] == 3'd7) || rx_last_i;
      wr_addr_d                      = ADDR_W'(idx >> 3);
    end

    // Ready rises one cycle after entering READY so the final word is stored.
    ready_d = ((state_q == S_READY) || (state_q == S_READY_DROP)) &&
              ((state_d == S_READY) || (state_d == S_READY_DROP));
    drop_d  = drop_inc ? sat_inc(drop_q) : drop_q;
  end

  // State, packing and status registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pack_q    <= '0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      len_q     <= '0;
      ready_q   <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pack_q    <= pack_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      len_q     <= len_d;
      ready_q   <= ready_d;
      drop_q    <= drop_d;
    end
  end

  eth_rx_buf #(
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (wr_q),
    .waddr_i (wr_addr_q),
    .wdata_i (pack_q),
    .re_i    (rd_en_i),
    .raddr_i (rd_addr_i),
    .rdata_o (rd_data_o)
  );

  assign frame_ready_o = ready_q;
  assign frame_len_o   = len_q;
  assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_eth_rx_narrow.sv
// Self-checking bench for eth_rx_narrow with a byte-array reference model.
module tb_eth_rx_narrow;

  localparam int ADDR_W    = 8;
  localparam int MAX_BYTES = 2048;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [7:0]        rx_data_i = '0;
  logic              rx_valid_i = 1'b0;
  logic              rx_last_i = 1'b0;
  logic              rx_err_i = 1'b0;
  logic              frame_ready_o;
  logic [11:0]       frame_len_o;
  logic              frame_ack_i = 1'b0;
  logic              rd_en_i = 1'b0;
  logic [ADDR_W-1:0] rd_addr_i = '0;
  logic [63:0]       rd_data_o;
  logic [15:0]       drop_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_drop = 0;
  logic [7:0] fb [0:4095];

  eth_rx_narrow #(.ADDR_W(ADDR_W), .MAX_BYTES(MAX_BYTES)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rx_data_i     (rx_data_i),
    .rx_valid_i    (rx_valid_i),
    .rx_last_i     (rx_last_i),
    .rx_err_i      (rx_err_i),
    .frame_ready_o (frame_ready_o),
    .frame_len_o   (frame_len_o),
    .frame_ack_i   (frame_ack_i),
    .rd_en_i       (rd_en_i),
    .rd_addr_i     (rd_addr_i),
    .rd_data_o     (rd_data_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected word w of a frame of len bytes held in fb (little-endian lanes).
  function automatic logic [63:0] exp_word(input int w, input int len);
    logic [63:0] v;
    v = '0;
    for (int l = 0; l < 8; l++) begin
      if (8 * w + l < len) v[8*l +: 8] = fb[8*w + l];
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    rx_valid_i = 1'b0; rx_last_i = 1'b0; rx_err_i = 1'b0;
    frame_ack_i = 1'b0; rd_en_i = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    exp_drop = 0;
    tick();
  endtask

  task automatic fill(input int len, input bit seq);
    for (int k = 0; k < len; k++) fb[k] = seq ? 8'(k) : 8'($urandom);
  endtask

  // Streams a frame back-to-back; junk frames use random bytes, not fb.
  // Returns one step after the edge that accepted the last byte.
  task automatic send_frame(input int len, input bit err, input int ack_at, input bit junk);
    for (int i = 0; i < len; i++) begin
      rx_valid_i  = 1'b1;
      rx_data_i   = junk ? 8'($urandom) : fb[i];
      rx_last_i   = (i == len - 1);
      rx_err_i    = (i == len - 1) ? err : 1'($urandom_range(0, 1));
      frame_ack_i = (i == ack_at);
      tick();
    end
    rx_valid_i = 1'b0; rx_last_i = 1'b0; rx_err_i = 1'b0; frame_ack_i = 1'b0;
  endtask

  task automatic read_word(input int a, output logic [63:0] d);
    rd_en_i = 1'b1;
    rd_addr_i = ADDR_W'(a);
    tick();
    rd_en_i = 1'b0;
    d = rd_data_o;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick(); tick();
    n_tests++;
    if (frame_ready_o !== 1'b0 || frame_len_o !== 12'd0 || rd_data_o !== 64'd0 || drop_cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL reset: got ready=%b len=%0d rd=%h drop=%0d, expected all zero",
               frame_ready_o, frame_len_o, rd_data_o, drop_cnt_o);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_frame64();
    logic [63:0] d, held;
    fill(64, 1'b1);
    send_frame(64, 1'b0, -1, 1'b0);
    n_tests++;
    if (frame_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL f64_early_ready: got %b expected 0", frame_ready_o);
    end
    tick();
    n_tests++;
    if (frame_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL f64_ready: got %b expected 1", frame_ready_o);
    end
    n_tests++;
    if (frame_len_o !== 12'd64) begin
      n_fail++; $display("FAIL f64_len: got %0d expected 64", frame_len_o);
    end
    read_word(0, d);
    n_tests++;
    if (d !== 64'h0706050403020100) begin
      n_fail++; $display("FAIL f64_word0: got %h expected 0706050403020100", d);
    end
    for (int w = 1; w < 8; w++) begin
      read_word(w, d);
      n_tests++;
      if (d !== exp_word(w, 64)) begin
        n_fail++; $display("FAIL f64_word%0d: got %h expected %h", w, d, exp_word(w, 64));
      end
    end
    held = d;
    rd_addr_i = ADDR_W'(2);
    tick(); tick();
    n_tests++;
    if (rd_data_o !== held) begin
      n_fail++; $display("FAIL rd_hold: got %h expected %h", rd_data_o, held);
    end
    frame_ack_i = 1'b1;
    tick();
    frame_ack_i = 1'b0;
    n_tests++;
    if (frame_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL f64_ack: got ready %b expected 0", frame_ready_o);
    end
  endtask

  task automatic test_frame13();
    logic [63:0] d;
    fill(13, 1'b1);
    send_frame(13, 1'b0, 4, 1'b0);
    tick();
    n_tests++;
    if (frame_ready_o !== 1'b1 || frame_len_o !== 12'd13) begin
      n_fail++; $display("FAIL f13_ready_len: got ready=%b len=%0d expected 1/13", frame_ready_o, frame_len_o);
    end
    read_word(1, d);
    n_tests++;
    if (d !== 64'h0000000C0B0A0908) begin
      n_fail++; $display("FAIL f13_word1: got %h expected 0000000c0b0a0908", d);
    end
    read_word(0, d);
    n_tests++;
    if (d !== exp_word(0, 13)) begin
      n_fail++; $display("FAIL f13_word0: got %h expected %h", d, exp_word(0, 13));
    end
    frame_ack_i = 1'b1;
    tick();
    frame_ack_i = 1'b0;
  endtask

  task automatic test_err();
    logic seen;
    logic [63:0] d;
    do_reset();
    fill(30, 1'b0);
    send_frame(30, 1'b1, -1, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      seen |= frame_ready_o;
      tick();
    end
    exp_drop++;
    n_tests++;
    if (seen !== 1'b0 || drop_cnt_o !== 16'(exp_drop)) begin
      n_fail++; $display("FAIL err_frame: got ready_seen=%b drop=%0d expected 0/%0d", seen, drop_cnt_o, exp_drop);
    end
    fill(9, 1'b0);
    send_frame(9, 1'b0, -1, 1'b0);
    tick();
    n_tests++;
    if (frame_ready_o !== 1'b1 || frame_len_o !== 12'd9) begin
      n_fail++; $display("FAIL err_recover: got ready=%b len=%0d expected 1/9", frame_ready_o, frame_len_o);
    end
    read_word(1, d);
    n_tests++;
    if (d !== exp_word(1, 9)) begin
      n_fail++; $display("FAIL err_recover_word1: got %h expected %h", d, exp_word(1, 9));
    end
    frame_ack_i = 1'b1;
    tick();
    frame_ack_i = 1'b0;
  endtask

  task automatic test_oversize();
    logic [63:0] d;
    do_reset();
    fill(2049, 1'b0);
    send_frame(2049, 1'b0, -1, 1'b0);
    tick(); tick(); tick();
    exp_drop++;
    n_tests++;
    if (frame_ready_o !== 1'b0 || drop_cnt_o !== 16'(exp_drop)) begin
      n_fail++; $display("FAIL over2049: got ready=%b drop=%0d expected 0/%0d", frame_ready_o, drop_cnt_o, exp_drop);
    end
    fill(2048, 1'b0);
    send_frame(2048, 1'b0, -1, 1'b0);
    tick();
    n_tests++;
    if (frame_ready_o !== 1'b1 || frame_len_o !== 12'd2048) begin
      n_fail++; $display("FAIL max2048: got ready=%b len=%0d expected 1/2048", frame_ready_o, frame_len_o);
    end
    for (int w = 0; w < 256; w++) begin
      read_word(w, d);
      n_tests++;
      if (d !== exp_word(w, 2048)) begin
        n_fail++; $display("FAIL max2048_word%0d: got %h expected %h", w, d, exp_word(w, 2048));
      end
    end
    frame_ack_i = 1'b1;
    tick();
    frame_ack_i = 1'b0;
    send_frame(2100, 1'b0, -1, 1'b1);
    tick(); tick();
    exp_drop++;
    n_tests++;
    if (frame_ready_o !== 1'b0 || drop_cnt_o !== 16'(exp_drop)) begin
      n_fail++; $display("FAIL over2100: got ready=%b drop=%0d expected 0/%0d", frame_ready_o, drop_cnt_o, exp_drop);
    end
  endtask

  task automatic test_ready_hold();
    logic [63:0] d;
    do_reset();
    fill(20, 1'b0);
    send_frame(20, 1'b0, -1, 1'b0);
    tick();
    send_frame(1, 1'b0, -1, 1'b1);
    exp_drop++;
    tick();
    n_tests++;
    if (frame_ready_o !== 1'b1 || frame_len_o !== 12'd20 || drop_cnt_o !== 16'(exp_drop)) begin
      n_fail++; $display("FAIL hold_1byte: got ready=%b len=%0d drop=%0d expected 1/20/%0d",
                         frame_ready_o, frame_len_o, drop_cnt_o, exp_drop);
    end
    send_frame(7, 1'b0, -1, 1'b1);
    exp_drop++;
    tick();
    n_tests++;
    if (frame_ready_o !== 1'b1 || frame_len_o !== 12'd20 || drop_cnt_o !== 16'(exp_drop)) begin
      n_fail++; $display("FAIL hold_7byte: got ready=%b len=%0d drop=%0d expected 1/20/%0d",
                         frame_ready_o, frame_len_o, drop_cnt_o, exp_drop);
    end
    for (int w = 0; w < 3; w++) begin
      read_word(w, d);
      n_tests++;
      if (d !== exp_word(w, 20)) begin
        n_fail++; $display("FAIL hold_word%0d: got %h expected %h", w, d, exp_word(w, 20));
      end
    end
    frame_ack_i = 1'b1;
    tick();
    frame_ack_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    do_reset();
    fill(16, 1'b0);
    send_frame(16, 1'b0, -1, 1'b0);
    tick();
    n_tests++;
    if (frame_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first_ready: got %b expected 1", frame_ready_o);
    end
    send_frame(12, 1'b0, 5, 1'b1);
    exp_drop++;
    tick();
    n_tests++;
    if (frame_ready_o !== 1'b0 || drop_cnt_o !== 16'(exp_drop)) begin
      n_fail++; $display("FAIL b2b_second_drop: got ready=%b drop=%0d expected 0/%0d", frame_ready_o, drop_cnt_o, exp_drop);
    end
    fill(27, 1'b0);
    send_frame(27, 1'b0, -1, 1'b0);
    n_tests++;
    if (frame_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_third_early: got %b expected 0", frame_ready_o);
    end
    tick();
    n_tests++;
    if (frame_ready_o !== 1'b1 || frame_len_o !== 12'd27) begin
      n_fail++; $display("FAIL b2b_third: got ready=%b len=%0d expected 1/27", frame_ready_o, frame_len_o);
    end
    for (int w = 0; w < 4; w++) begin
      read_word(w, d);
      n_tests++;
      if (d !== exp_word(w, 27)) begin
        n_fail++; $display("FAIL b2b_word%0d: got %h expected %h", w, d, exp_word(w, 27));
      end
    end
    frame_ack_i = 1'b1;
    tick();
    frame_ack_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    for (int i = 0; i < 10; i++) begin
      rx_valid_i = 1'b1; rx_data_i = 8'($urandom); rx_last_i = 1'b0;
      tick();
    end
    rx_valid_i = 1'b0;
    rst_ni = 1'b0;
    tick();
    n_tests++;
    if (frame_ready_o !== 1'b0 || frame_len_o !== 12'd0 || rd_data_o !== 64'd0 || drop_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL reset_mid: got ready=%b len=%0d rd=%h drop=%0d expected all zero",
                         frame_ready_o, frame_len_o, rd_data_o, drop_cnt_o);
    end
    rst_ni = 1'b1;
    exp_drop = 0;
    tick();
    fill(21, 1'b0);
    send_frame(21, 1'b0, -1, 1'b0);
    tick();
    n_tests++;
    if (frame_ready_o !== 1'b1 || frame_len_o !== 12'd21 || drop_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL reset_mid_next: got ready=%b len=%0d drop=%0d expected 1/21/0",
                         frame_ready_o, frame_len_o, drop_cnt_o);
    end
    for (int w = 0; w < 3; w++) begin
      read_word(w, d);
      n_tests++;
      if (d !== exp_word(w, 21)) begin
        n_fail++; $display("FAIL reset_mid_word%0d: got %h expected %h", w, d, exp_word(w, 21));
      end
    end
    frame_ack_i = 1'b1;
    tick();
    frame_ack_i = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0] d;
    int len;
    bit err;
    for (int it = 0; it < 10; it++) begin
      len = $urandom_range(1, 300);
      err = ($urandom_range(0, 3) == 0);
      fill(len, 1'b0);
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        frame_ack_i = 1'($urandom_range(0, 1));
        tick();
      end
      frame_ack_i = 1'b0;
      send_frame(len, err, -1, 1'b0);
      if (err) begin
        exp_drop++;
        tick(); tick();
        n_tests++;
        if (frame_ready_o !== 1'b0 || drop_cnt_o !== 16'(exp_drop)) begin
          n_fail++; $display("FAIL rand%0d_err: got ready=%b drop=%0d expected 0/%0d", it, frame_ready_o, drop_cnt_o, exp_drop);
        end
      end else begin
        tick();
        n_tests++;
        if (frame_ready_o !== 1'b1 || frame_len_o !== 12'(len)) begin
          n_fail++; $display("FAIL rand%0d_len: got ready=%b len=%0d expected 1/%0d", it, frame_ready_o, frame_len_o, len);
        end
        for (int w = 0; w < (len + 7) / 8; w++) begin
          read_word(w, d);
          n_tests++;
          if (d !== exp_word(w, len)) begin
            n_fail++; $display("FAIL rand%0d_word%0d: got %h expected %h", it, w, d, exp_word(w, len));
          end
        end
        frame_ack_i = 1'b1;
        tick();
        frame_ack_i = 1'b0;
        n_tests++;
        if (frame_ready_o !== 1'b0) begin
          n_fail++; $display("FAIL rand%0d_ack: got ready %b expected 0", it, frame_ready_o);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame64();
    test_frame13();
    test_err();
    test_oversize();
    test_ready_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
